// File: rtl/cmp_pipe_if.sv
// Request/response bundle for cmp_pipe: request handshake, operands,
// flush, and the result handshake with its flags.
interface cmp_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       Op;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             Flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Carry;
  logic             Overflow;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_valid, Op, In1, In2, Flush, out_ready,
    input  in_ready, out_valid, Out, Carry, Overflow, Zero, Negative
  );

  modport slave (
    input  in_valid, Op, In1, In2, Flush, out_ready,
    output in_ready, out_valid, Out, Carry, Overflow, Zero, Negative
  );
endinterface

// File: rtl/cmp_pipe.sv
// Slice-serial add/subtract/compare unit. An accepted request is processed
// SLICE bits per cycle from the LSB, rippling the carry through a register,
// and the result plus flags are presented once the last slice is done.
// WIDTH must be a non-zero multiple of SLICE.
module cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic       clk,
  input logic       rst,
  cmp_pipe_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_CMPS = 2'b10;
  localparam logic [1:0] OP_CMPU = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [1:0]       op;
  logic             cin;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             carry_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] out_next;
  logic             ovf_next;
  logic             accept;
  logic             last;
  int               base;

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = out_valid_r;
  assign bus.Out       = out_r;
  assign bus.Carry     = carry_r;
  assign bus.Overflow  = ovf_r;
  assign bus.Zero      = zero_r;
  assign bus.Negative  = neg_r;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (k == KW'(N - 1));

  // Add the current slice and build the full result/flags as they would be
  // if this were the final slice; only used when last is set.
  always_comb begin
    base      = int'(k) * SLICE;
    slice_sum = {1'b0, op_a[base +: SLICE]} + {1'b0, op_b[base +: SLICE]}
                + {{SLICE{1'b0}}, cin};
    res_next  = res;
    res_next[base +: SLICE] = slice_sum[SLICE-1:0];
    ovf_next  = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (res_next[WIDTH-1] != op_a[WIDTH-1]);
    out_next  = '0;
    case (op)
      OP_CMPS: out_next[0] = res_next[WIDTH-1] ^ ovf_next;
      OP_CMPU: out_next[0] = ~slice_sum[SLICE];
      default: out_next    = res_next;
    endcase
  end

  // Control FSM: accept, step one slice per BUSY cycle, hold result in DONE.
  // Flush beats everything; visible outputs change only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res         <= '0;
      op          <= OP_SUB;
      cin         <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
    end else if (bus.Flush) begin
      state       <= IDLE;
      k           <= '0;
      out_valid_r <= 1'b0;
    end else if (accept) begin
      op_a        <= bus.In1;
      op_b        <= (bus.Op == OP_ADD) ? bus.In2 : ~bus.In2;
      op          <= bus.Op;
      cin         <= (bus.Op != OP_ADD);
      k           <= '0;
      state       <= BUSY;
      out_valid_r <= 1'b0;
    end else if ((state == DONE) && bus.out_ready) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
    end else if (state == BUSY) begin
      res <= res_next;
      cin <= slice_sum[SLICE];
      if (last) begin
        state       <= DONE;
        out_valid_r <= 1'b1;
        out_r       <= out_next;
        carry_r     <= slice_sum[SLICE];
        ovf_r       <= ovf_next;
        zero_r      <= (res_next == '0);
        neg_r       <= res_next[WIDTH-1];
      end else begin
        k <= k + 1'b1;
      end
    end
  end
endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, giving the bits processed per BUSY cycle; WIDTH SHALL be a non-zero multiple of SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 Op  input  2  operation: 00 SUB (In1-In2), 01 ADD (In1+In2), 10 CMPS (signed less-than), 11 CMPU (unsigned less-than).
REQ-008 In1  input  WIDTH  first operand.
REQ-009 In2  input  WIDTH  second operand.
REQ-010 Flush  input  1  synchronous abort of any operation in progress.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 Out  output  WIDTH  result.
REQ-014 Carry  output  1  carry-out of the slice chain.
REQ-015 Overflow  output  1  signed overflow.
REQ-016 Zero  output  1  arithmetic result equals 0.
REQ-017 Negative  output  1  MSB of the arithmetic result.

Function
REQ-018 FSM states SHALL be IDLE, BUSY and DONE; N = WIDTH/SLICE.
REQ-019 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready); it SHALL be low in BUSY.
REQ-020 Acceptance SHALL occur on an edge with in_valid & in_ready, registering In1, In2 and Op, clearing the slice counter, and setting the carry-in (1 for SUB/CMPS/CMPU, 0 for ADD); the state SHALL become BUSY.
REQ-021 Each BUSY edge SHALL add slice k of In1 to slice k of the second term (In2 for ADD, ~In2 otherwise) plus the stored carry, write slice k of the arithmetic result, store the slice carry-out, and increment k, starting from the LSB.
REQ-022 The edge processing slice N-1 SHALL move the state to DONE and set out_valid=1; latency SHALL be exactly N+1 edges from acceptance to out_valid high.
REQ-023 Carry SHALL be the final slice carry-out; for SUB, 1 means no borrow.
REQ-024 Overflow SHALL be (In1[MSB] == term2[MSB]) & (result[MSB] != In1[MSB]), where term2 is the second addend actually used.
REQ-025 Zero and Negative SHALL be taken from the WIDTH-bit arithmetic result in all modes.
REQ-026 Out SHALL be the arithmetic result for ADD/SUB, {zeros, Negative^Overflow} for CMPS, and {zeros, ~Carry} for CMPU.
REQ-027 In DONE, out_valid SHALL stay high and Out/flags stable until out_valid & out_ready at an edge.
REQ-028 On that edge the state SHALL go to IDLE, or to BUSY if in_valid is also high (back-to-back acceptance).
REQ-029 Out and the flags SHALL hold their last values in IDLE and BUSY; they SHALL update only on the edge entering DONE.
REQ-030 out_valid SHALL be low in IDLE and BUSY.
REQ-031 Flush SHALL force the state to IDLE and out_valid to 0 on the next edge, taking precedence over acceptance and completion; Out and the flags SHALL keep their values.
REQ-032 The WIDTH==SLICE case SHALL complete in one BUSY cycle.

Reset
REQ-033 While rst=1, the block SHALL immediately force state=IDLE, k=0, out_valid=0, Out=0, Carry=0, Overflow=0, Zero=0 and Negative=0, independent of clk.
REQ-034 in_ready SHALL be 1 after reset.
REQ-035 Reset asserted in BUSY or DONE SHALL discard the operation in progress with no out_valid pulse.

Verification (WIDTH=32, SLICE=8)
REQ-036 SUB 0x00000005-0x00000007 -> out_valid after 5 edges; Out=0xFFFFFFFE, Carry=0, Overflow=0, Negative=1, Zero=0.
REQ-037 ADD 0x7FFFFFFF+0x00000001 -> Out=0x80000000, Overflow=1, Carry=0; ADD 0xFFFFFFFF+1 -> Out=0, Carry=1, Zero=1.
REQ-038 CMPS 0xFFFFFFFF vs 0x00000001 -> Out=1; CMPU on the same operands -> Out=0.
REQ-039 out_ready held low 3 cycles in DONE -> Out stable and in_ready=0; raising out_ready with in_valid high -> next operation accepted on the same edge, no IDLE cycle.
REQ-040 Flush in the 2nd BUSY cycle -> IDLE next edge, no out_valid, previous Out retained; rst pulse mid-BUSY -> all outputs 0 immediately.
